// File: rtl/sbox_pair_sched.sv
// Issue scheduler for the dual-lane masked S-box: pairs shared bytes into A/B slots, gates on
// fresh randomness, tracks in-flight pairs and buffers results. Build option: SBOX_CLEAR_EN.
module sbox_pair_sched #(
  parameter int unsigned SBOX_LAT   = 4,
  parameter int unsigned NBYTES     = 16,
  parameter int unsigned RND_W      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [7:0]                in_sh0_i,
  input  logic [7:0]                in_sh1_i,
  input  logic                      rnd_valid_i,
  output logic                      rnd_ready_o,
  input  logic [RND_W-1:0]          rnd_a_i,
  input  logic [RND_W-1:0]          rnd_b_i,
  output logic                      iss_o,
  output logic [7:0]                sa_sh0_o,
  output logic [7:0]                sa_sh1_o,
  output logic [7:0]                sb_sh0_o,
  output logic [7:0]                sb_sh1_o,
  output logic [RND_W-1:0]          ra_o,
  output logic [RND_W-1:0]          rb_o,
  input  logic [7:0]                res_a_sh0_i,
  input  logic [7:0]                res_a_sh1_i,
  input  logic [7:0]                res_b_sh0_i,
  input  logic [7:0]                res_b_sh1_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [$clog2(NBYTES)-1:0] out_idx_o,
  output logic [7:0]                out_sh0_o,
  output logic [7:0]                out_sh1_o
);

  localparam int unsigned IdxW  = $clog2(NBYTES);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW  = IdxW + 16;
  localparam int unsigned InflW = $clog2(SBOX_LAT + 1) + 1;
  localparam logic [IdxW:0]   NBytesC  = (IdxW + 1)'(NBYTES);
  localparam logic [IdxW-1:0] LastPair = IdxW'(NBYTES / 2 - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW:0]       in_cnt_q, in_cnt_d;
  logic [IdxW-1:0]     iss_cnt_q, iss_cnt_d;
  logic                ha_v_q, ha_v_d, hb_v_q, hb_v_d;
  logic [15:0]         ha_q, ha_d, hb_q, hb_d;
  logic                sl_v_q   [SBOX_LAT];
  logic [IdxW-1:0]     sl_idx_q [SBOX_LAT];
  logic [EntW-1:0]     mem_q    [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       fifo_cnt_q, fifo_cnt_d;
  logic [InflW-1:0]    inflight;
  logic [IdxW-1:0]     idx_a;
  logic                issue_go, accept, push, pop;
  int                  space;

  // Free slots after reserving two FIFO entries per pair still in the shift line.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < SBOX_LAT; i++) begin
      inflight = inflight + InflW'(sl_v_q[i]);
    end
    space = int'(FIFO_DEPTH) - int'(fifo_cnt_q) - 2 * int'(inflight);
  end

  assign idx_a       = iss_cnt_q << 1;
  assign issue_go    = (state_q == StFill) && ha_v_q && hb_v_q && rnd_valid_i && (space >= 2);
  assign in_ready_o  = (state_q == StFill) && (in_cnt_q < NBytesC) &&
                       (!(ha_v_q && hb_v_q) || issue_go);
  assign accept      = in_valid_i && in_ready_o;
  assign push        = sl_v_q[SBOX_LAT-1];
  assign out_valid_o = (fifo_cnt_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign iss_o       = issue_go;
  assign rnd_ready_o = issue_go;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign {out_idx_o, out_sh0_o, out_sh1_o} = out_valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = accept ? in_cnt_q + 1'b1 : in_cnt_q;
    iss_cnt_d = issue_go ? iss_cnt_q + 1'b1 : iss_cnt_q;
    ha_v_d    = ha_v_q && !issue_go;
    hb_v_d    = hb_v_q && !issue_go;
    ha_d      = ha_q;
    hb_d      = hb_q;
    if (accept) begin
      if (!ha_v_d) begin
        ha_v_d = 1'b1;
        ha_d   = {in_sh0_i, in_sh1_i};
      end else begin
        hb_v_d = 1'b1;
        hb_d   = {in_sh0_i, in_sh1_i};
      end
    end
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StFill;
          in_cnt_d  = '0;
          iss_cnt_d = '0;
        end
      end
      StFill:  if (issue_go && iss_cnt_q == LastPair) state_d = StDrain;
      // Leave as the final result is popped so done lands one cycle after it.
      StDrain: if (inflight == '0 && (fifo_cnt_q == '0 || (fifo_cnt_q == 1 && pop))) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push) fifo_cnt_d = fifo_cnt_d + (PtrW + 1)'(2);
    if (pop)  fifo_cnt_d = fifo_cnt_d - (PtrW + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_cnt_q   <= '0;
      iss_cnt_q  <= '0;
      ha_v_q     <= 1'b0;
      hb_v_q     <= 1'b0;
      ha_q       <= '0;
      hb_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int unsigned i = 0; i < SBOX_LAT; i++) begin
        sl_v_q[i]   <= 1'b0;
        sl_idx_q[i] <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      iss_cnt_q  <= iss_cnt_d;
      ha_v_q     <= ha_v_d;
      hb_v_q     <= hb_v_d;
      ha_q       <= ha_d;
      hb_q       <= hb_d;
      fifo_cnt_q <= fifo_cnt_d;
      sl_v_q[0]   <= issue_go;
      sl_idx_q[0] <= idx_a;
      for (int unsigned i = 1; i < SBOX_LAT; i++) begin
        sl_v_q[i]   <= sl_v_q[i-1];
        sl_idx_q[i] <= sl_idx_q[i-1];
      end
      if (push) begin
        mem_q[wr_ptr_q]              <= {sl_idx_q[SBOX_LAT-1], res_a_sh0_i, res_a_sh1_i};
        mem_q[wr_ptr_q + PtrW'(1)]   <= {sl_idx_q[SBOX_LAT-1] + IdxW'(1), res_b_sh0_i, res_b_sh1_i};
        wr_ptr_q                     <= wr_ptr_q + PtrW'(2);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

`ifdef SBOX_CLEAR_EN
  // Lanes carry shares only in the issue cycle.
  assign {sa_sh0_o, sa_sh1_o} = issue_go ? ha_q : '0;
  assign {sb_sh0_o, sb_sh1_o} = issue_go ? hb_q : '0;
  assign ra_o                 = issue_go ? rnd_a_i : '0;
  assign rb_o                 = issue_go ? rnd_b_i : '0;
`else
  logic [15:0]      sa_last_q, sb_last_q;
  logic [RND_W-1:0] ra_last_q, rb_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_last_q <= '0;
      sb_last_q <= '0;
      ra_last_q <= '0;
      rb_last_q <= '0;
    end else if (issue_go) begin
      sa_last_q <= ha_q;
      sb_last_q <= hb_q;
      ra_last_q <= rnd_a_i;
      rb_last_q <= rnd_b_i;
    end
  end

  assign {sa_sh0_o, sa_sh1_o} = issue_go ? ha_q : sa_last_q;
  assign {sb_sh0_o, sb_sh1_o} = issue_go ? hb_q : sb_last_q;
  assign ra_o                 = issue_go ? rnd_a_i : ra_last_q;
  assign rb_o                 = issue_go ? rnd_b_i : rb_last_q;
`endif

endmodule

// File: tb/tb_sbox_pair_sched.sv
// Randomized scoreboard bench for sbox_pair_sched with a behavioural S-box datapath model.
module tb_sbox_pair_sched;
  localparam int unsigned LAT = 4, NB = 16, RW = 4, DEPTH = 8, IW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, busy, done, in_valid = 1'b0, in_ready;
  logic [7:0] in_sh0 = '0, in_sh1 = '0;
  logic rnd_valid = 1'b0, rnd_ready;
  logic [RW-1:0] rnd_a = '0, rnd_b = '0, ra, rb;
  logic iss;
  logic [7:0] sa0, sa1, sb0, sb1, ra0, ra1, rb0, rb1;
  logic out_valid, out_ready = 1'b0;
  logic [IW-1:0] out_idx;
  logic [7:0] out_sh0, out_sh1;

  always #5 clk = ~clk;

  sbox_pair_sched #(.SBOX_LAT(LAT), .NBYTES(NB), .RND_W(RW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sh0_i(in_sh0), .in_sh1_i(in_sh1),
    .rnd_valid_i(rnd_valid), .rnd_ready_o(rnd_ready), .rnd_a_i(rnd_a), .rnd_b_i(rnd_b),
    .iss_o(iss), .sa_sh0_o(sa0), .sa_sh1_o(sa1), .sb_sh0_o(sb0), .sb_sh1_o(sb1),
    .ra_o(ra), .rb_o(rb),
    .res_a_sh0_i(ra0), .res_a_sh1_i(ra1), .res_b_sh0_i(rb0), .res_b_sh1_i(rb1),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_idx_o(out_idx),
    .out_sh0_o(out_sh0), .out_sh1_o(out_sh1)
  );

  int n_chk = 0, n_pass = 0;
  int unsigned rnd_pct = 100, ord_pct = 100;
  logic [IW+15:0] exp_q[$];
  int iss_times[$];
  int cyc = 0, acc_cnt = 0, iss_m = 0, pass_pop = 0, issued = 0, popped = 0, matured = 0;
  bit active = 0, fill = 0, done_exp = 0;
  logic [7:0] b0 [NB];
  logic [7:0] b1 [NB];
  logic [39:0] last_lane = '0;
  logic [31:0] lane_s = '0;
  logic [31:0] dp_q [LAT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Datapath model: shares+1 on sh0, sh1^A5, exactly LAT cycles after issue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dp_q[i] <= '0;
    end else begin
      dp_q[0] <= lane_s;
      for (int i = 1; i < LAT; i++) dp_q[i] <= dp_q[i-1];
    end
  end
  assign ra0 = dp_q[LAT-1][31:24] + 8'd1;
  assign ra1 = dp_q[LAT-1][23:16] ^ 8'hA5;
  assign rb0 = dp_q[LAT-1][15:8] + 8'd1;
  assign rb1 = dp_q[LAT-1][7:0] ^ 8'hA5;

  always @(negedge clk) begin
    #1;
    rnd_valid = ($urandom_range(99) < rnd_pct);
    rnd_a     = RW'($urandom);
    rnd_b     = RW'($urandom);
    out_ready = ($urandom_range(99) < ord_pct);
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    int held, outst;
    bit ei, nd, st;
    logic [39:0] lane, idle;
    logic [IW+15:0] e;
    #2;
    cyc++;
    lane_s = {sa0, sa1, sb0, sb1};
    if (!rst_n) begin
      chk("reset_ctrl", {busy, done, in_ready, rnd_ready, iss, out_valid}, '0);
      chk("reset_data", {sa0, sa1, sb0, sb1, ra, rb, out_idx, out_sh0, out_sh1}, '0);
      exp_q.delete(); iss_times.delete();
      active = 0; fill = 0; done_exp = 0; last_lane = '0;
      acc_cnt = 0; iss_m = 0; pass_pop = 0; issued = 0; popped = 0; matured = 0;
    end else begin
      while (iss_times.size() > 0 && iss_times[0] + LAT + 1 <= cyc) begin
        void'(iss_times.pop_front());
        matured += 2;
      end
      held  = acc_cnt - 2 * iss_m;
      outst = 2 * issued - popped;
      ei    = fill && held == 2 && rnd_valid && (int'(DEPTH) - outst >= 2);
      chk("iss", iss, ei);
      chk("rnd_ready", rnd_ready, ei);
      chk("in_ready", in_ready, fill && acc_cnt < NB && (held < 2 || ei));
      chk("busy", busy, active);
      chk("done", done, done_exp);
      chk("out_valid", out_valid, (matured - popped) > 0);
      if (iss && ei) begin
        lane = {b0[2*iss_m], b1[2*iss_m], b0[2*iss_m+1], b1[2*iss_m+1], rnd_a, rnd_b};
        chk("lanes_issue", {sa0, sa1, sb0, sb1, ra, rb}, lane);
        last_lane = lane;
      end else if (!iss) begin
`ifdef SBOX_CLEAR_EN
        idle = '0;
`else
        idle = last_lane;
`endif
        chk("lanes_idle", {sa0, sa1, sb0, sb1, ra, rb}, idle);
      end
      if (done_exp) chk("iss_per_pass", iss_m, NB / 2);
      nd = 0;
      if (out_valid && out_ready) begin
        chk("out_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", {out_idx, out_sh0, out_sh1}, e);
        end
        popped++; pass_pop++;
        nd = (pass_pop == NB);
      end
      if (in_valid && in_ready && acc_cnt < NB) begin
        b0[acc_cnt] = in_sh0;
        b1[acc_cnt] = in_sh1;
        exp_q.push_back({IW'(acc_cnt), in_sh0 + 8'd1, in_sh1 ^ 8'hA5});
        acc_cnt++;
      end
      if (iss) begin
        iss_m++; issued++;
        iss_times.push_back(cyc);
        if (iss_m == NB / 2) fill = 0;
      end
      st = start && !active;
      if (done_exp) active = 0;
      if (st) begin
        active = 1; fill = 1; acc_cnt = 0; iss_m = 0; pass_pop = 0;
      end
      done_exp = nd;
    end
  end

  task automatic send_byte(input logic [7:0] s0, input logic [7:0] s1);
    int budget = 300;
    bit got = 0;
    in_sh0 = s0; in_sh1 = s1; in_valid = 1'b1;
    while (!got && budget > 0) begin
      #3 got = in_ready;
      @(negedge clk);
      budget--;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_chk++;
      $display("FAIL byte_accept: in_ready stayed 0 for 300 cycles, expected 1");
    end
  endtask

  task automatic feed(input int n, input int unsigned gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap)) @(negedge clk);
      send_byte(8'($urandom), 8'($urandom));
    end
  endtask

  task automatic start_pass();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 3000;
    while (active && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_chk++;
      $display("FAIL pass_end: busy model still 1 after 3000 cycles, expected 0");
    end
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    int budget;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Full pass, ideal conditions.
    start_pass(); feed(NB, 0); wait_idle();
    // Reset mid-fill with pairs in flight.
    start_pass(); feed(6, 0);
    budget = 50;
    while (iss_m < 3 && budget > 0) begin @(negedge clk); budget--; end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    // Randomness stall with both holds full.
    start_pass(); feed(2, 0);
    rnd_pct = 0;
    repeat (10) @(negedge clk);
    rnd_pct = 100;
    feed(NB - 2, 0); wait_idle();
    // Output backpressure.
    ord_pct = 0;
    fork
      begin start_pass(); feed(NB, 0); end
      begin repeat (40) @(negedge clk); ord_pct = 100; end
    join
    wait_idle();
    // Randomized passes.
    for (int p = 0; p < 8; p++) begin
      rnd_pct = $urandom_range(100, 30);
      ord_pct = $urandom_range(100, 20);
      start_pass(); feed(NB, $urandom_range(2)); wait_idle();
    end
    // Back-to-back: start held through DONE and the following IDLE cycle.
    rnd_pct = 100; ord_pct = 100;
    start_pass(); feed(NB, 0);
    budget = 500;
    while (!done_exp && budget > 0) begin @(negedge clk); budget--; end
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    feed(NB, 1); wait_idle();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
